// File: rtl/demodulation_bit_packer.sv
// -----------------------------------------------------------------------------
// demodulation_bit_packer
//
// Purpose:
//   Takes the stream of signed Q16.16 segment decisions coming out of the
//   demodulation stages, hard-decides each accepted segment to one bit
//   (strictly positive -> 1, zero or negative -> 0) and packs NUM_SEG bits
//   into a word. Segment 0 lands in bit 0. The finished word is presented on
//   word_out together with a one-cycle valid pulse. word_out only changes when
//   a complete word is published, or when reset clears it.
//
// Ports:
//   clk        in   1                  single clock, rising edge
//   reset      in   1                  synchronous, active-high
//   start      in   1                  begin collecting a new word (pulse)
//   seg_in     in   DATA_W             segment value, signed Q16.16
//   seg_valid  in   1                  seg_in valid this cycle
//   word_out   out  NUM_SEG            packed decisions, segment 0 in bit 0
//   valid      out  1                  one-cycle pulse: word_out updated
//   busy       out  1                  high while collecting
//   err_count  out  $clog2(NUM_SEG+1)  non-nominal segments in the last word
//                                      (only with DEMOD_PACK_ERR_COUNT_EN)
//
// Configuration:
//   DEMOD_PACK_ERR_COUNT_EN  when defined, adds the ONE_VAL parameter, the
//                            err_count port and a per-word counter of
//                            segments that are neither +ONE_VAL nor -ONE_VAL.
// -----------------------------------------------------------------------------
module demodulation_bit_packer #(
    parameter int NUM_SEG = 10,
    parameter int DATA_W  = 32
`ifdef DEMOD_PACK_ERR_COUNT_EN
    ,
    parameter logic [DATA_W-1:0] ONE_VAL = 32'h00010000
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_W-1:0]            seg_in,
    input  logic                         seg_valid,
    output logic [NUM_SEG-1:0]           word_out,
    output logic                         valid,
    output logic                         busy
`ifdef DEMOD_PACK_ERR_COUNT_EN
    ,
    output logic [$clog2(NUM_SEG+1)-1:0] err_count
`endif
);

    // Index needs at least one bit even when NUM_SEG == 1.
    localparam int IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_SEG-1:0]   bits_q, bits_d;   // word under construction
    logic [NUM_SEG-1:0]   word_q, word_d;   // last published word
    logic                 seg_bit;

`ifdef DEMOD_PACK_ERR_COUNT_EN
    localparam int ERR_W = $clog2(NUM_SEG + 1);
    localparam logic [DATA_W-1:0] NEG_ONE_VAL = -ONE_VAL;

    logic [ERR_W-1:0]     err_q, err_d;         // running count for this word
    logic [ERR_W-1:0]     err_out_q, err_out_d; // count of last published word
    logic                 seg_nominal;
`endif

    // Strictly positive: sign bit clear and not all-zero.
    assign seg_bit = ~seg_in[DATA_W-1] & (seg_in != '0);

`ifdef DEMOD_PACK_ERR_COUNT_EN
    assign seg_nominal = (seg_in == ONE_VAL) || (seg_in == NEG_ONE_VAL);
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave a value unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        bits_d  = bits_q;
        word_d  = word_q;
`ifdef DEMOD_PACK_ERR_COUNT_EN
        err_d     = err_q;
        err_out_d = err_out_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // A segment arriving with start in IDLE is dropped.
                if (start) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                    bits_d  = '0;
`ifdef DEMOD_PACK_ERR_COUNT_EN
                    err_d   = '0;
`endif
                end
            end

            ST_COLLECT: begin
                // start is ignored here: the word in progress always finishes.
                if (seg_valid) begin
                    bits_d[idx_q] = seg_bit;
`ifdef DEMOD_PACK_ERR_COUNT_EN
                    if (!seg_nominal) begin
                        err_d = err_q + ERR_W'(1);
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        // Publish on the final accept so word_out is already
                        // updated in the cycle valid is high.
                        state_d   = ST_DONE;
                        idx_d     = '0;
                        word_d    = bits_d;
`ifdef DEMOD_PACK_ERR_COUNT_EN
                        err_out_d = err_d;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                    bits_d  = '0;
`ifdef DEMOD_PACK_ERR_COUNT_EN
                    err_d   = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            bits_q    <= '0;
            word_q    <= '0;
`ifdef DEMOD_PACK_ERR_COUNT_EN
            err_q     <= '0;
            err_out_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bits_q    <= bits_d;
            word_q    <= word_d;
`ifdef DEMOD_PACK_ERR_COUNT_EN
            err_q     <= err_d;
            err_out_q <= err_out_d;
`endif
        end
    end

    // Both decoded from the state register, so they are glitch-free.
    assign valid    = (state_q == ST_DONE);
    assign busy     = (state_q == ST_COLLECT);
    assign word_out = word_q;
`ifdef DEMOD_PACK_ERR_COUNT_EN
    assign err_count = err_out_q;
`endif

endmodule

// File: tb/tb_demodulation_bit_packer.sv
// -----------------------------------------------------------------------------
// tb_demodulation_bit_packer
//
// Scoreboard bench for demodulation_bit_packer. The driver decides, per word,
// which segment values it sends and computes the expected word (sign/zero
// rule), error count and publication cycle with plain arithmetic, pushing the
// result into a queue. An independent monitor on the falling edge pops and
// compares whenever valid is high, and otherwise checks that word_out holds.
// Build with +define+DEMOD_PACK_ERR_COUNT_EN to also check err_count.
// -----------------------------------------------------------------------------
module tb_demodulation_bit_packer;

    localparam int NUM_SEG = 10;
    localparam int DATA_W  = 32;
    localparam logic [31:0] P1 = 32'h0001_0000;
    localparam logic [31:0] M1 = 32'hFFFF_0000;

    typedef struct {
        logic [NUM_SEG-1:0] word;
        int                 errs;
        int                 cycle;
    } exp_t;

    logic                clk;
    logic                reset;
    logic                start;
    logic [DATA_W-1:0]   seg_in;
    logic                seg_valid;
    logic [NUM_SEG-1:0]  word_out;
    logic                valid;
    logic                busy;
`ifdef DEMOD_PACK_ERR_COUNT_EN
    logic [$clog2(NUM_SEG+1)-1:0] err_count;
`endif

    demodulation_bit_packer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .word_out  (word_out),
        .valid     (valid),
        .busy      (busy)
`ifdef DEMOD_PACK_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   mon_en = 0;
    bit   exp_busy = 0;
    logic [NUM_SEG-1:0] hold_word = '0;
    int   hold_errs = 0;
    exp_t exp_q[$];
    int   valid_cycles[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decision: strictly positive signed value -> 1.
    function automatic bit decide(input logic [31:0] v);
        return $signed(v) > 0;
    endfunction

    function automatic bit is_err(input logic [31:0] v);
        return (v != P1) && (v != M1);
    endfunction

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid=1, expected no word pending (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word", 32'(word_out), 32'(e.word));
                    check("valid_cycle", cyc, e.cycle);
`ifdef DEMOD_PACK_ERR_COUNT_EN
                    check("err_count", 32'(err_count), e.errs);
`endif
                    hold_word = e.word;
                    hold_errs = e.errs;
                    valid_cycles.push_back(cyc);
                end
            end else begin
                check("word_hold", 32'(word_out), 32'(hold_word));
`ifdef DEMOD_PACK_ERR_COUNT_EN
                check("err_hold", 32'(err_count), hold_errs);
`endif
            end
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        seg_valid = 1'b0;
        seg_in    = $urandom;
        step();
        exp_busy  = 0;
        hold_word = '0;
        hold_errs = 0;
        mon_en    = 1;
        check("rst_word", 32'(word_out), 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef DEMOD_PACK_ERR_COUNT_EN
        check("rst_err", 32'(err_count), 32'd0);
`endif
        step();
        reset = 1'b0;
    endtask

    // Idle cycles with optional junk seg_valid pulses that must be ignored.
    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            seg_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            seg_in    = $urandom;
            step();
        end
        seg_valid = 1'b0;
    endtask

    // Issue start (in IDLE or DONE) and stream vals with random gaps. When
    // noise_start is set, start is also waved around during collection.
    task automatic send_word(input logic [31:0] vals[$], input int max_gap, input bit noise_start);
        logic [NUM_SEG-1:0] w;
        int errs;
        w    = '0;
        errs = 0;
        start     = 1'b1;
        seg_valid = 1'($urandom_range(0, 1));   // dropped by the DUT
        seg_in    = $urandom;
        step();
        exp_busy = 1;
        for (int i = 0; i < vals.size(); i++) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                start     = noise_start ? 1'($urandom_range(0, 1)) : 1'b0;
                seg_valid = 1'b0;
                seg_in    = $urandom;
                step();
            end
            start     = noise_start ? 1'($urandom_range(0, 1)) : 1'b0;
            seg_valid = 1'b1;
            seg_in    = vals[i];
            w[i]      = decide(vals[i]);
            errs     += int'(is_err(vals[i]));
            step();
        end
        exp_busy = 0;
        exp_q.push_back('{word: w, errs: errs, cycle: cyc});
        start     = 1'b0;
        seg_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_seg();
        case ($urandom_range(0, 4))
            0, 1:    return P1;
            2:       return M1;
            3:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] v[$];
        reset     = 1'b0;
        start     = 1'b0;
        seg_valid = 1'b0;
        seg_in    = '0;
        step();
        do_reset();

        // Alternating +1/-1, no gaps.
        v = {};
        for (int i = 0; i < NUM_SEG; i++) v.push_back((i % 2 == 0) ? P1 : M1);
        send_word(v, 0, 0);
        check("t1_valid", {31'd0, valid}, 32'd1);
        check("t1_word", 32'(word_out), 32'h155);
        check("t1_busy", {31'd0, busy}, 32'd0);
        idle(2, 0);

        // Same pattern with gaps of 0..3 cycles.
        send_word(v, 3, 0);
        idle(1, 0);

        // Boundary values: zero, smallest positive, most negative.
        v = {32'd0, 32'd1, 32'h8000_0000};
        for (int i = 0; i < 7; i++) v.push_back(P1);
        send_word(v, 1, 0);
        check("t3_word", 32'(word_out), 32'h3FA);
`ifdef DEMOD_PACK_ERR_COUNT_EN
        check("t3_err", 32'(err_count), 32'd3);
`endif
        idle(3, 0);

        // Reset after 5 accepts, then an all -1.0 word.
        start = 1'b1;
        step();
        exp_busy = 1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seg_valid = 1'b1;
            seg_in    = P1;
            step();
        end
        seg_valid = 1'b0;
        do_reset();
        idle(2, 0);
        v = {};
        for (int i = 0; i < NUM_SEG; i++) v.push_back(M1);
        send_word(v, 2, 0);
        idle(1, 0);

        // start waved during collection, then back-to-back words.
        valid_cycles = {};
        v = {};
        for (int i = 0; i < NUM_SEG; i++) v.push_back(rand_seg());
        send_word(v, 0, 1);
        v = {};
        for (int i = 0; i < NUM_SEG; i++) v.push_back(rand_seg());
        send_word(v, 0, 0);   // start issued in the DONE cycle
        idle(2, 0);
        check("t5_valid_count", valid_cycles.size(), 32'd2);
        if (valid_cycles.size() == 2)
            check("t5_spacing", valid_cycles[1] - valid_cycles[0], 32'd11);

        // Junk seg_valid in IDLE before start.
        idle(6, 1);
        v = {};
        for (int i = 0; i < NUM_SEG; i++) v.push_back(P1);
        send_word(v, 0, 0);
        idle(1, 0);

        // Randomized words: gaps, stray starts, mixed back-to-back / idle.
        for (int k = 0; k < 30; k++) begin
            v = {};
            for (int i = 0; i < NUM_SEG; i++) v.push_back(rand_seg());
            send_word(v, 3, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4), 1);
        end

        idle(4, 0);
        check("pending_words", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
